hex_text_fmt: RTL and testbench
===============================

Name: hex_text_fmt

Overview:
- Upstream feeder for the UART debug text sender.
- Accepts binary words (e.g. PS/2 scancodes), buffers them in a small FIFO, and converts each word serially into fixed-format ASCII.
- Format: prefix char, ':', uppercase hex digits MS first, CR, LF.
- Presents the result as a flat text bus with a request/acknowledge/busy handshake to the sender.

Parameters:
- DIGITS, 4, hex digits per word; input width 4*DIGITS. Range 1..12.
- PREFIX, 8'h4B ("K"), first character of every line.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
- TEXT_LEN (derived, not overridable) = DIGITS+4 characters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word strobe.
- in_data  in  4*DIGITS  word to format.
- in_ready  out  1  FIFO not full.
- text_req  out  1  text ready for sender; held until text_ack.
- text_ack  in  1  one-cycle pulse: sender captured the request.
- text_busy  in  1  high while the sender is reading debug_text (from the text_ack cycle until the last character is sent).
- debug_text  out  8*TEXT_LEN  ASCII line; character 0 in bits [8*TEXT_LEN-1 -: 8], last character in bits [7:0].
- drop_cnt  out  8  saturating count of words dropped while full.

Behaviour:
- Reset (one cycle, any state):
  - State goes to IDLE; FIFO is emptied and its contents discarded.
  - text_req=0, debug_text=0, drop_cnt=0; in_ready=1 from the next cycle.
  - In-flight conversion is aborted.
- FIFO:
  - in_ready = !full (combinational from registered count).
  - Push when in_valid && in_ready.
  - in_valid && !in_ready: word dropped; drop_cnt increments, saturating at 255.
  - Pop only in IDLE when not empty and text_busy=0.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if pop condition holds, latch the head word into the shift register, write debug_text bytes 0,1 = PREFIX, ':' and bytes TEXT_LEN-2, TEXT_LEN-1 = 8'h0D, 8'h0A, then go to CONV with digit index 0.
  - CONV: each cycle, convert the top nibble n into a character: n<10 gives 8'h30+n, otherwise 8'h37+n ('A'-'F'). Write it to character 2+index, shift the word left by 4, increment index. After DIGITS cycles, set text_req<=1 and go to REQ.
  - REQ: text_req held at 1. On text_ack, clear text_req and go to WAIT.
  - WAIT: when text_busy=0, go to IDLE.
  - text_ack outside REQ is ignored. text_busy has no effect outside IDLE/WAIT.
- Stability: debug_text changes only in the IDLE pop cycle and in CONV. It is constant throughout REQ and WAIT.
- Latency (idle, empty FIFO, text_busy=0): text_req rises DIGITS+1 cycles after the push edge (5 for default).
  - Back-to-back line rate is limited by the sender.
  - Minimum spacing between text_req rises is DIGITS+3 cycles plus the busy time.
- text_req never rises while text_busy=1 from a previous line.

Test Plan:
- Reset, push 16'h1C5A, ack 2 cycles after req, busy 10 cycles -> text_req at cycle 5 after push. debug_text = "K:1C5A\r\n" (4B 3A 31 43 35 41 0D 0A), stable until busy falls.
- Push 16'hF0E9, hold off text_ack 20 cycles -> text_req stays 1 and debug_text stays "K:F0E9\r\n". After ack, text_req=0 next cycle.
- Hold text_busy=1 and push 6 words back-to-back -> in_ready falls after 4 accepted, 2 dropped, drop_cnt=2. Release busy and ack each line -> 4 lines emitted in push order.
- Push 300 words while full -> drop_cnt saturates at 255.
- Assert reset mid-CONV and again in REQ -> next cycle text_req=0, debug_text=0, FIFO empty, in_ready=1. A new push then produces a correct line.
- DIGITS=2, PREFIX=8'h50, push 8'h0A -> debug_text = "P:0A\r\n", text_req 3 cycles after push.

Source files
------------

// File: rtl/hex_text_fmt_if.sv
// Handshake bundle between the word source, hex_text_fmt and the UART text sender.
interface hex_text_fmt_if #(
  parameter int DIGITS = 4
);
  localparam int TEXT_LEN = DIGITS + 4;

  logic                    in_valid;
  logic [4*DIGITS-1:0]     in_data;
  logic                    in_ready;
  logic                    text_req;
  logic                    text_ack;
  logic                    text_busy;
  logic [8*TEXT_LEN-1:0]   debug_text;
  logic [7:0]              drop_cnt;

  modport master (
    output in_valid, in_data, text_ack, text_busy,
    input  in_ready, text_req, debug_text, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, text_ack, text_busy,
    output in_ready, text_req, debug_text, drop_cnt
  );
endinterface

// File: rtl/hex_text_fmt.sv
// Buffers binary words in a small FIFO and renders each as "<PREFIX>:<hex>\r\n"
// on a flat text bus, handed to the UART sender via req/ack/busy.
module hex_text_fmt #(
  parameter int          DIGITS     = 4,
  parameter logic [7:0]  PREFIX     = 8'h4B,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  hex_text_fmt_if.slave bus
);
  localparam int W        = 4 * DIGITS;
  localparam int TEXT_LEN = DIGITS + 4;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int IW       = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_REQ,
    S_WAIT
  } state_t;

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic [7:0]            drop_q;
  logic                  full, empty, push, pop;

  state_t                state_q;
  logic [W-1:0]          shift_q;
  logic [IW-1:0]         idx_q;
  logic [8*TEXT_LEN-1:0] text_q;
  logic                  req_q;
  logic [3:0]            nib;
  logic [7:0]            hex_ch;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty && !bus.text_busy;

  assign bus.in_ready   = !full;
  assign bus.text_req   = req_q;
  assign bus.debug_text = text_q;
  assign bus.drop_cnt   = drop_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bus.in_valid && full && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign nib = shift_q[W-1 -: 4];

  always_comb begin
    hex_ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      text_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q                     <= mem_q[rd_ptr_q];
            text_q[8*TEXT_LEN-1 -: 16]  <= {PREFIX, 8'h3A};
            text_q[15:0]                <= 16'h0D0A;
            idx_q                       <= '0;
            state_q                     <= S_CONV;
          end
        end
        S_CONV: begin
          // Digit k lands in character 2+k, counted from the MS byte.
          for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) text_q[8*(TEXT_LEN-3-k) +: 8] <= hex_ch;
          end
          shift_q <= shift_q << 4;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == IW'(DIGITS-1)) begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.text_ack) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.text_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_text_fmt.sv
// Scoreboard bench for hex_text_fmt: default 4-digit instance plus a 2-digit "P" instance.
module tb_hex_text_fmt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hex_text_fmt_if #(.DIGITS(4)) bus0 ();
  hex_text_fmt_if #(.DIGITS(2)) bus1 ();

  hex_text_fmt #(.DIGITS(4), .PREFIX(8'h4B), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  hex_text_fmt #(.DIGITS(2), .PREFIX(8'h50), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int passes = 0;
  logic [63:0] sb_q [$];

  function automatic logic [63:0] exp_text(input logic [15:0] w);
    logic [63:0] r;
    logic [3:0]  n;
    r = {8'h4B, 8'h3A, 32'h0, 8'h0D, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      n = w[15-4*i -: 4];
      r[47-8*i -: 8] = (n < 10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [15:0] w, output bit acc);
    acc = bus0.in_ready;
    bus0.in_valid = 1'b1;
    bus0.in_data  = w;
    cyc();
    bus0.in_valid = 1'b0;
    if (acc) sb_q.push_back(exp_text(w));
  endtask

  task automatic wait_req0(output int n);
    n = 0;
    while (bus0.text_req !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL reset_req got %b exp 0", bus0.text_req); else passes++;
    checks++; if (bus0.debug_text !== 64'h0) $display("FAIL reset_text got %h exp 0", bus0.debug_text); else passes++;
    checks++; if (bus0.drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d exp 0", bus0.drop_cnt); else passes++;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus0.in_ready); else passes++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    bit acc;
    int n;
    logic [63:0] e;
    push0(16'h1C5A, acc);
    wait_req0(n);
    checks++; if (n !== 5) $display("FAIL basic_latency got %0d exp 5", n); else passes++;
    e = sb_q.pop_front();
    checks++; if (bus0.debug_text !== e) $display("FAIL basic_text got %h exp %h", bus0.debug_text, e); else passes++;
    checks++; if (bus0.debug_text !== 64'h4B3A314335410D0A) $display("FAIL basic_literal got %h exp 4B3A314335410D0A", bus0.debug_text); else passes++;
    cyc();
    cyc();
    bus0.text_ack = 1'b1;
    bus0.text_busy = 1'b1;
    cyc();
    bus0.text_ack = 1'b0;
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL basic_req_clr got %b exp 0", bus0.text_req); else passes++;
    repeat (10) cyc();
    checks++; if (bus0.debug_text !== e) $display("FAIL basic_busy_stable got %h exp %h", bus0.debug_text, e); else passes++;
    bus0.text_busy = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_hold_ack();
    bit acc;
    int n;
    int bad = 0;
    logic [63:0] e;
    push0(16'hF0E9, acc);
    wait_req0(n);
    checks++; if (bus0.text_req !== 1'b1) $display("FAIL hold_timeout got %b exp 1", bus0.text_req); else passes++;
    e = sb_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      if (bus0.text_req !== 1'b1 || bus0.debug_text !== e) bad++;
      cyc();
    end
    checks++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad); else passes++;
    checks++; if (bus0.debug_text !== 64'h4B3A463045390D0A) $display("FAIL hold_text got %h exp 4B3A463045390D0A", bus0.debug_text); else passes++;
    bus0.text_ack = 1'b1;
    bus0.text_busy = 1'b1;
    cyc();
    bus0.text_ack = 1'b0;
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL hold_req_clr got %b exp 0", bus0.text_req); else passes++;
    cyc();
    bus0.text_busy = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n;
    int accepted = 0;
    logic [63:0] e;
    logic [15:0] words [6] = '{16'h0001, 16'hABCD, 16'h9F30, 16'h7E42, 16'h5555, 16'h6666};
    bus0.text_busy = 1'b1;
    cyc();
    foreach (words[i]) begin
      push0(words[i], acc);
      if (acc) accepted++;
    end
    checks++; if (accepted !== 4) $display("FAIL b2b_accepted got %0d exp 4", accepted); else passes++;
    checks++; if (bus0.in_ready !== 1'b0) $display("FAIL b2b_ready got %b exp 0", bus0.in_ready); else passes++;
    checks++; if (bus0.drop_cnt !== 8'd2) $display("FAIL b2b_drop got %0d exp 2", bus0.drop_cnt); else passes++;
    repeat (3) cyc();
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL b2b_busy_block got %b exp 0", bus0.text_req); else passes++;
    bus0.text_busy = 1'b0;
    for (int l = 0; l < 4; l++) begin
      wait_req0(n);
      checks++; if (bus0.text_req !== 1'b1) $display("FAIL b2b_timeout line %0d got %b exp 1", l, bus0.text_req); else passes++;
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'h0;
      checks++; if (bus0.debug_text !== e) $display("FAIL b2b_line%0d got %h exp %h", l, bus0.debug_text, e); else passes++;
      bus0.text_ack = 1'b1;
      bus0.text_busy = 1'b1;
      cyc();
      bus0.text_ack = 1'b0;
      repeat (3) cyc();
      bus0.text_busy = 1'b0;
      cyc();
    end
  endtask

  task automatic test_saturate();
    bit acc;
    bus0.text_busy = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) push0(16'(i * 16'h1111), acc);
    for (int i = 0; i < 300; i++) push0(16'hDEAD, acc);
    checks++; if (bus0.drop_cnt !== 8'd255) $display("FAIL sat_drop got %0d exp 255", bus0.drop_cnt); else passes++;
    bus0.text_busy = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_q.delete();
    checks++; if (bus0.drop_cnt !== 8'd0) $display("FAIL sat_reset_drop got %0d exp 0", bus0.drop_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    bit acc;
    int n;
    int rises = 0;
    logic [63:0] e;
    push0(16'h2468, acc);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_q.delete();
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL conv_rst_req got %b exp 0", bus0.text_req); else passes++;
    checks++; if (bus0.debug_text !== 64'h0) $display("FAIL conv_rst_text got %h exp 0", bus0.debug_text); else passes++;
    checks++; if (bus0.in_ready !== 1'b1) $display("FAIL conv_rst_ready got %b exp 1", bus0.in_ready); else passes++;
    push0(16'h1357, acc);
    wait_req0(n);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_q.delete();
    checks++; if (bus0.text_req !== 1'b0) $display("FAIL req_rst_req got %b exp 0", bus0.text_req); else passes++;
    checks++; if (bus0.debug_text !== 64'h0) $display("FAIL req_rst_text got %h exp 0", bus0.debug_text); else passes++;
    for (int i = 0; i < 10; i++) begin
      if (bus0.text_req !== 1'b0) rises++;
      cyc();
    end
    checks++; if (rises !== 0) $display("FAIL rst_fifo_empty got %0d req cycles exp 0", rises); else passes++;
    push0(16'hBEEF, acc);
    wait_req0(n);
    checks++; if (n !== 5) $display("FAIL post_rst_latency got %0d exp 5", n); else passes++;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'h0;
    checks++; if (bus0.debug_text !== e) $display("FAIL post_rst_text got %h exp %h", bus0.debug_text, e); else passes++;
    bus0.text_ack = 1'b1;
    cyc();
    bus0.text_ack = 1'b0;
    cyc();
  endtask

  task automatic test_digits2();
    int n = 0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h0A;
    cyc();
    bus1.in_valid = 1'b0;
    while (bus1.text_req !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    checks++; if (n !== 3) $display("FAIL d2_latency got %0d exp 3", n); else passes++;
    checks++; if (bus1.debug_text !== 48'h503A30410D0A) $display("FAIL d2_text got %h exp 503A30410D0A", bus1.debug_text); else passes++;
    bus1.text_ack = 1'b1;
    cyc();
    bus1.text_ack = 1'b0;
    checks++; if (bus1.text_req !== 1'b0) $display("FAIL d2_req_clr got %b exp 0", bus1.text_req); else passes++;
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.text_ack = 1'b0; bus0.text_busy = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.text_ack = 1'b0; bus1.text_busy = 1'b0;
    test_reset();
    test_basic();
    test_hold_ack();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_digits2();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
